// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing and hazard controller for the 5-stage RV32I pipeline: start gating,
// load-use/branch stall-flush, data-memory freeze with timeout, stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int A_WIDTH   = 5,
    parameter int TIMEOUT   = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic [A_WIDTH-1:0]   Rs1D,
    input  logic [A_WIDTH-1:0]   Rs2D,
    input  logic [A_WIDTH-1:0]   RdE,
    input  logic [1:0]           ResultSrcE,
    input  logic                 PCSrcE,
    input  logic                 MemReqM,
    input  logic                 MemReadyM,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 StallE,
    output logic                 StallM,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic                 FlushW,
    output logic                 running,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] stall_cycles
);

    localparam int WC_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0]      WC_ZERO  = {WC_W{1'b0}};
    localparam logic [WC_W-1:0]      WC_ONE   = WC_W'(1);
    localparam logic [WC_W-1:0]      WC_LAST  = WC_W'(TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_MEMWAIT = 2'b10,
        ST_ERROR   = 2'b11
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [WC_W-1:0]      wait_cnt_r;
    logic [WC_W-1:0]      wait_cnt_s;
    logic [CNT_WIDTH-1:0] stall_cycles_r;
    logic                 running_r;
    logic                 err_r;
    logic                 lw_s;
    logic                 freeze_s;
    logic                 active_s;

    // Saturating increment for the performance counter.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + CNT_ONE;
        end
    endfunction

    // Hazard detection terms.
    always_comb begin
        lw_s     = (ResultSrcE == 2'b01) && (RdE != {A_WIDTH{1'b0}})
                   && ((RdE == Rs1D) || (RdE == Rs2D));
        freeze_s = MemReqM && !MemReadyM;
        active_s = (state_r == ST_RUN) || (state_r == ST_MEMWAIT);
    end

    // Next-state, wait counter and Mealy stall/flush decode.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (trigger) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
                wait_cnt_s = WC_ZERO;
            end
            ST_RUN, ST_MEMWAIT: begin
                // A memory freeze holds the whole front end; a pending branch stays in E.
                if (freeze_s) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end else begin
                    StallF = lw_s;
                    StallD = lw_s;
                    FlushD = PCSrcE;
                    FlushE = lw_s | PCSrcE;
                end
                if (!freeze_s) begin
                    state_s    = ST_RUN;
                    wait_cnt_s = WC_ZERO;
                end else if (state_r == ST_RUN) begin
                    state_s    = ST_MEMWAIT;
                    wait_cnt_s = WC_ONE;
                end else if (wait_cnt_r == WC_LAST) begin
                    state_s    = ST_ERROR;
                    wait_cnt_s = wait_cnt_r;
                end else begin
                    state_s    = ST_MEMWAIT;
                    wait_cnt_s = wait_cnt_r + WC_ONE;
                end
            end
            ST_ERROR: begin
                StallF     = 1'b1;
                StallD     = 1'b1;
                StallE     = 1'b1;
                StallM     = 1'b1;
                FlushW     = 1'b1;
                state_s    = ST_ERROR;
                wait_cnt_s = wait_cnt_r;
            end
            default: begin
                StallF     = 1'b1;
                StallD     = 1'b1;
                FlushD     = 1'b1;
                FlushE     = 1'b1;
                state_s    = ST_IDLE;
                wait_cnt_s = WC_ZERO;
            end
        endcase
    end

    // State, wait counter and registered status decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= WC_ZERO;
            running_r  <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            running_r  <= (state_s == ST_RUN) || (state_s == ST_MEMWAIT);
            err_r      <= (state_s == ST_ERROR);
        end
    end

    // Stall-cycle performance counter; frozen outside RUN/MEMWAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_r <= CNT_ZERO;
        end else if (active_s && StallF) begin
            stall_cycles_r <= sat_inc(stall_cycles_r);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    assign running      = running_r;
    assign err          = err_r;
    assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          trigger;
    logic [4:0]    Rs1D, Rs2D, RdE;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MemReqM, MemReadyM;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic          running, err;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_ctrl #(.A_WIDTH(5), .TIMEOUT(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .trigger(trigger),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdE(RdE), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .running(running), .err(err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // ctl = {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW}
    localparam logic [6:0] C_IDLE = 7'b1100110;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LW   = 7'b1100010;
    localparam logic [6:0] C_BR   = 7'b0000110;
    localparam logic [6:0] C_BRLW = 7'b1100110;
    localparam logic [6:0] C_FRZ  = 7'b1111001;

    typedef struct packed {
        int            id;
        logic [6:0]    ctl;
        logic          run;
        logic          er;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            vec_id   = 0;
    logic [CW-1:0] exp_cnt  = '0;

    // One clock cycle of stimulus plus its expected response.
    task automatic cyc(input logic rst, input logic trig, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [1:0] rsrc, input logic pcs,
                       input logic mreq, input logic mrdy,
                       input logic [6:0] ctl, input logic run, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = rst; trigger = trig; Rs1D = rs1; Rs2D = rs2; RdE = rd;
        ResultSrcE = rsrc; PCSrcE = pcs; MemReqM = mreq; MemReadyM = mrdy;
        if (!rst) exp_cnt = '0;
        e.id = vec_id; e.ctl = ctl; e.run = run; e.er = er; e.cnt = exp_cnt;
        sb.push_back(e);
        vec_id++;
        if (rst && run && ctl[6] && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s vec%0d: got %0h expected %0h", name, id, got, want);
    endtask

    // Monitor: compare whenever an expectation is pending for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("ctl", e.id, {25'd0, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}, {25'd0, e.ctl});
            chk("running", e.id, {31'd0, running}, {31'd0, e.run});
            chk("err", e.id, {31'd0, err}, {31'd0, e.er});
            chk("stall_cycles", e.id, {28'd0, stall_cycles}, {28'd0, e.cnt});
        end
    end

    initial begin
        rst_n = 1'b0; trigger = 1'b0; Rs1D = '0; Rs2D = '0; RdE = '0;
        ResultSrcE = 2'b00; PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
        // reset, then idle with trigger low
        cyc(0,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        cyc(0,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        for (int i = 0; i < 3; i++) cyc(1,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        // hazard inputs are ignored in IDLE; trigger pulse starts the run
        cyc(1,0, 0,5,5,2'b01,1,1,0, C_IDLE,0,0);
        cyc(1,1, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        cyc(1,0, 0,0,0,2'b00,0,0,0, C_NONE,1,0);
        // load-use on Rs2, then RdE=0, non-load, Rs1 match
        cyc(1,0, 0,5,5,2'b01,0,0,0, C_LW,1,0);
        cyc(1,0, 0,0,0,2'b00,0,0,0, C_NONE,1,0);
        cyc(1,0, 0,0,0,2'b01,0,0,0, C_NONE,1,0);
        cyc(1,1, 5,0,5,2'b00,0,0,0, C_NONE,1,0);
        cyc(1,0, 7,3,7,2'b01,0,0,0, C_LW,1,0);
        // branch alone, branch with load hazard
        cyc(1,0, 0,0,0,2'b00,1,0,0, C_BR,1,0);
        cyc(1,0, 9,1,9,2'b01,1,0,0, C_BRLW,1,0);
        // memory wait of 3 cycles, branch pulse hidden by the freeze
        cyc(1,0, 9,1,9,2'b01,0,1,0, C_FRZ,1,0);
        cyc(1,0, 0,0,0,2'b00,1,1,0, C_FRZ,1,0);
        cyc(1,0, 0,0,0,2'b00,1,1,0, C_FRZ,1,0);
        cyc(1,0, 0,0,0,2'b00,1,1,1, C_BR,1,0);
        cyc(1,0, 0,0,0,2'b00,0,1,1, C_NONE,1,0);
        // timeout: 16 freeze cycles, then sticky error
        for (int i = 0; i < 16; i++) cyc(1,0, 0,0,0,2'b00,0,1,0, C_FRZ,1,0);
        cyc(1,0, 0,0,0,2'b00,0,1,0, C_FRZ,0,1);
        cyc(1,1, 0,0,0,2'b00,1,1,1, C_FRZ,0,1);
        cyc(1,0, 3,0,3,2'b01,0,0,0, C_FRZ,0,1);
        // reset mid-error
        cyc(0,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        cyc(1,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        cyc(1,1, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        // 20 consecutive load-use stalls saturate a 4-bit counter
        for (int i = 0; i < 20; i++) cyc(1,0, 4,0,4,2'b01,0,0,0, C_LW,1,0);
        cyc(1,0, 0,0,0,2'b00,0,0,0, C_NONE,1,0);
        // freeze then reset mid-MEMWAIT
        cyc(1,0, 0,0,0,2'b00,0,1,0, C_FRZ,1,0);
        cyc(1,0, 0,0,0,2'b00,0,1,0, C_FRZ,1,0);
        cyc(0,0, 0,0,0,2'b00,0,1,0, C_IDLE,0,0);
        cyc(1,0, 0,0,0,2'b00,0,0,0, C_IDLE,0,0);
        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage RV32I pipeline.
- Holds the pipeline idle until the start trigger.
- In run, drives per-stage stall/flush for load-use hazards, taken branches/jumps and data-memory wait states, and detects memory timeout.
- Sits beside the decode/execute register chain; its outputs feed the F/D/E/M/W pipeline register enables and clears.

Parameters:
- A_WIDTH, 5, register address width.
- TIMEOUT, 16, consecutive memory-freeze cycles that trigger the error state (must be ≥2).
- CNT_WIDTH, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- trigger  in  1  start request; sampled in IDLE only.
- Rs1D  in  A_WIDTH  decode-stage source register 1.
- Rs2D  in  A_WIDTH  decode-stage source register 2.
- RdE  in  A_WIDTH  execute-stage destination register.
- ResultSrcE  in  2  execute-stage result select; 2'b01 = load.
- PCSrcE  in  1  taken branch/jump resolved in execute.
- MemReqM  in  1  memory-stage data access in progress.
- MemReadyM  in  1  data memory completes the access this cycle.
- StallF  out  1  hold PC.
- StallD  out  1  hold F/D register.
- StallE  out  1  hold D/E register.
- StallM  out  1  hold E/M register.
- FlushD  out  1  clear F/D register.
- FlushE  out  1  clear D/E register.
- FlushW  out  1  clear M/W register (bubble into writeback).
- running  out  1  state is RUN or MEMWAIT.
- err  out  1  memory timeout; sticky until reset.
- stall_cycles  out  CNT_WIDTH  saturating count of stalled cycles.

Behaviour:
- States: IDLE, RUN, MEMWAIT, ERROR; 2-bit state register plus wait_cnt (clog2(TIMEOUT) bits).
- Reset (async, rst_n=0): state=IDLE, wait_cnt=0, stall_cycles=0, err=0, running=0. Outputs take IDLE values immediately.
- Derived terms (combinational):
  - lw = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - freeze = MemReqM && !MemReadyM.
- IDLE outputs: StallF=StallD=1, FlushD=FlushE=1, StallE=StallM=FlushW=0. Transition: trigger=1 → RUN next edge; otherwise stay.
- RUN/MEMWAIT outputs, same-cycle (Mealy), in priority order:
  - freeze=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0. Freeze overrides lw and PCSrcE; the branch is held in E and resolves after the freeze.
  - else: StallF=StallD=lw; FlushD=PCSrcE; FlushE=lw|PCSrcE; StallE=StallM=FlushW=0.
- RUN transition: freeze → MEMWAIT, wait_cnt←1; else stay, wait_cnt←0.
- MEMWAIT transitions:
  - !freeze → RUN, wait_cnt←0.
  - else if wait_cnt==TIMEOUT-1 → ERROR.
  - else wait_cnt←wait_cnt+1.
  - Net effect: ERROR is entered on the edge closing the TIMEOUT-th consecutive freeze cycle.
- ERROR outputs: StallF/D/E/M=1, FlushW=1, FlushD=FlushE=0, err=1, running=0. Only reset exits ERROR.
- trigger is ignored outside IDLE.
- stall_cycles: +1 on every edge where state∈{RUN,MEMWAIT} and StallF=1. Saturates at 2^CNT_WIDTH-1 with no wrap. Frozen in IDLE and ERROR.
- running and err are registered state decodes; no combinational path from inputs.
- Reset asserted mid-MEMWAIT or mid-ERROR: immediate return to IDLE values; counters cleared.

Test Plan:
- Start: reset, trigger=0 for 3 cycles → StallF=1, FlushE=1, running=0. Pulse trigger 1 cycle → next cycle running=1, StallF=0, FlushE=0.
- Load-use: RUN, ResultSrcE=01, RdE=5, Rs2D=5 → same cycle StallF=StallD=FlushE=1, FlushD=0; stall_cycles 0→1. Repeat with RdE=0 → no stall.
- Branch with load hazard: PCSrcE=1 and lw true together → FlushD=1, FlushE=1, StallF=1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 → freeze outputs for 3 cycles, state MEMWAIT after cycle 1, RUN after ready, stall_cycles +3, err=0. A PCSrcE=1 pulse during the freeze produces no flush.
- Timeout: TIMEOUT=16, freeze held 16 cycles → err=1 and running=0 after the 16th edge. MemReadyM=1 afterwards → stays ERROR. rst_n low → err=0, state IDLE.
- Saturation: CNT_WIDTH=4, force 20 consecutive load-use stalls → stall_cycles stops at 15.
